// File: rtl/full_adder_checker_if.sv
// ============================================================================
//  Module   : full_adder_checker_if
//  Brief    : Observation and result bundle for full_adder_checker.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface full_adder_checker_if;
   logic        start;
   logic        sample_en;
   logic        in1;
   logic        in2;
   logic        cin;
   logic        sum;
   logic        cout;
   logic        busy;
   logic        done;
   logic        pass;
   logic [7:0]  err_cnt;
   logic [15:0] sample_cnt;
   logic [4:0]  first_err_vec;
   logic [15:0] first_err_idx;

   // master drives the observed adder signals and reads back the results
   modport master (
      output start, sample_en, in1, in2, cin, sum, cout,
      input  busy, done, pass, err_cnt, sample_cnt, first_err_vec, first_err_idx
   );

   modport slave (
      input  start, sample_en, in1, in2, cin, sum, cout,
      output busy, done, pass, err_cnt, sample_cnt, first_err_vec, first_err_idx
   );
endinterface

`default_nettype wire

// File: rtl/full_adder_checker.sv
// ============================================================================
//  Module   : full_adder_checker
//  Brief    : Counts samples and mismatches of an observed 1-bit full adder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module full_adder_checker #(
   parameter int unsigned NUM_SAMPLES = 100,
   parameter bit          STOP_ON_ERR = 1'b0
) (
   input logic                 sys_clk,
   input logic                 sys_rst,
   full_adder_checker_if.slave bus
);

   localparam logic [15:0] C_NUM_SAMPLES = 16'(NUM_SAMPLES);
   localparam logic [7:0]  C_ERR_MAX     = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_busy;
   logic        r_done;
   logic        r_pass;
   logic [7:0]  r_err_cnt;
   logic [15:0] r_sample_cnt;
   logic [4:0]  r_first_err_vec;
   logic [15:0] r_first_err_idx;

   logic        w_busy_nxt;
   logic        w_done_nxt;
   logic        w_pass_nxt;
   logic [7:0]  w_err_cnt_nxt;
   logic [15:0] w_sample_cnt_nxt;
   logic [4:0]  w_first_err_vec_nxt;
   logic [15:0] w_first_err_idx_nxt;

   logic [4:0]  w_obs_vec;
   logic        w_exp_sum;
   logic        w_exp_cout;
   logic        w_mismatch;
   logic [15:0] w_sample_cnt_inc;

   assign w_obs_vec        = {bus.in1, bus.in2, bus.cin, bus.sum, bus.cout};
   assign w_exp_sum        = bus.in1 ^ bus.in2 ^ bus.cin;
   assign w_exp_cout       = (bus.in1 & bus.in2) | (bus.in1 & bus.cin) | (bus.in2 & bus.cin);
   assign w_mismatch       = bus.sample_en & ({bus.sum, bus.cout} != {w_exp_sum, w_exp_cout});
   assign w_sample_cnt_inc = r_sample_cnt + 16'd1;

   always_comb begin
      w_state_nxt         = r_state;
      w_err_cnt_nxt       = r_err_cnt;
      w_sample_cnt_nxt    = r_sample_cnt;
      w_first_err_vec_nxt = r_first_err_vec;
      w_first_err_idx_nxt = r_first_err_idx;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_state_nxt         = S_RUN;
               w_err_cnt_nxt       = 8'd0;
               w_sample_cnt_nxt    = 16'd0;
               w_first_err_vec_nxt = 5'd0;
               w_first_err_idx_nxt = 16'd0;
            end
         end
         S_RUN: begin
            if (bus.sample_en) begin
               w_sample_cnt_nxt = w_sample_cnt_inc;
               if (w_mismatch) begin
                  if (r_err_cnt != C_ERR_MAX) begin
                     w_err_cnt_nxt = r_err_cnt + 8'd1;
                  end
                  // err_cnt only ever grows within a run, so zero marks the first miss
                  if (r_err_cnt == 8'd0) begin
                     w_first_err_vec_nxt = w_obs_vec;
                     w_first_err_idx_nxt = r_sample_cnt;
                  end
               end
               if ((w_sample_cnt_inc == C_NUM_SAMPLES) || (STOP_ON_ERR && w_mismatch)) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt == S_RUN);
      w_done_nxt = (w_state_nxt == S_DONE);
      w_pass_nxt = (w_state_nxt == S_DONE) && (w_err_cnt_nxt == 8'd0);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state         <= S_IDLE;
         r_busy          <= 1'b0;
         r_done          <= 1'b0;
         r_pass          <= 1'b0;
         r_err_cnt       <= 8'd0;
         r_sample_cnt    <= 16'd0;
         r_first_err_vec <= 5'd0;
         r_first_err_idx <= 16'd0;
      end else begin
         r_state         <= w_state_nxt;
         r_busy          <= w_busy_nxt;
         r_done          <= w_done_nxt;
         r_pass          <= w_pass_nxt;
         r_err_cnt       <= w_err_cnt_nxt;
         r_sample_cnt    <= w_sample_cnt_nxt;
         r_first_err_vec <= w_first_err_vec_nxt;
         r_first_err_idx <= w_first_err_idx_nxt;
      end
   end

   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.pass          = r_pass;
   assign bus.err_cnt       = r_err_cnt;
   assign bus.sample_cnt    = r_sample_cnt;
   assign bus.first_err_vec = r_first_err_vec;
   assign bus.first_err_idx = r_first_err_idx;

endmodule

`default_nettype wire
